hlogic16_pipe: RTL and testbench



---
 rtl/hlogic16_pipe_if.sv | 31 +++
 rtl/hlogic16_pipe.sv | 124 ++++++++++++
 tb/tb_hlogic16_pipe.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hlogic16_pipe_if.sv
// Operand/result handshake bundle for hlogic16_pipe.
//   in_valid/in_ready  : operand beat handshake (a, b, op, acc_en, acc_clr)
//   out_valid/out_ready: result beat handshake (out, out_zr)
//   acc                : accumulator value, debug visibility
// slave is the pipeline's view, master is the source/consumer side.
interface hlogic16_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_zr;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, out, out_zr, acc
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, out, out_zr, acc
    );
endinterface

// File: rtl/hlogic16_pipe.sv
// Pipelined bitwise logic unit with accumulator and zero flag.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : hlogic16_pipe_if.slave
//           in : in_valid, a, b, op, acc_en, acc_clr, out_ready
//           out: in_ready, out_valid, out, out_zr, acc
// op: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 PASS a.
// Result is computed and registered into stage 0; later stages are delay
// registers with bubble collapse. Latency is STAGES cycles when unstalled.
module hlogic16_pipe #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] ACC_INIT = '1
) (
    input  logic           clk,
    input  logic           reset,
    hlogic16_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    op_e                          op_sel;
    logic [WIDTH-1:0]             a_eff;
    logic [WIDTH-1:0]             result;
    logic [WIDTH-1:0]             acc_q, acc_d;
    logic                         accept;

    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            zr_q, zr_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;

    // Per-stage source (stage 0 takes the new result, stage k takes k-1)
    // and load enable (stage may take new contents this cycle).
    logic [STAGES-1:0]            vld_src;
    logic [STAGES-1:0]            zr_src;
    logic [STAGES-1:0][WIDTH-1:0] data_src;
    logic [STAGES-1:0]            load;

    assign op_sel = op_e'(bus.op);

    always_comb begin
        a_eff  = (bus.acc_en && !bus.acc_clr) ? acc_q : bus.a;
        result = '0;
        case (op_sel)
            OP_AND:   result = a_eff & bus.b;
            OP_OR:    result = a_eff | bus.b;
            OP_XOR:   result = a_eff ^ bus.b;
            OP_NAND:  result = ~(a_eff & bus.b);
            OP_NOR:   result = ~(a_eff | bus.b);
            OP_XNOR:  result = ~(a_eff ^ bus.b);
            OP_NOTA:  result = ~a_eff;
            OP_PASSA: result = a_eff;
            default:  result = '0;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign vld_src[k]  = bus.in_valid;
            assign zr_src[k]   = (result == '0);
            assign data_src[k] = result;
        end else begin : g_tail
            assign vld_src[k]  = vld_q[k-1];
            assign zr_src[k]   = zr_q[k-1];
            assign data_src[k] = data_q[k-1];
        end

        // The advance chain "k moves if k+1 is empty or moving" unrolls to:
        // stage k may load unless it and every stage after it is full while
        // the output is stalled. Written as a reduction to avoid a
        // self-referencing combinational chain.
        assign load[k] = bus.out_ready || !(&vld_q[STAGES-1:k]);

        // Data/flag only move with a valid beat; a bubble just clears valid.
        assign vld_d[k]  = load[k] ? vld_src[k] : vld_q[k];
        assign zr_d[k]   = (load[k] && vld_src[k]) ? zr_src[k] : zr_q[k];
        assign data_d[k] = (load[k] && vld_src[k]) ? data_src[k] : data_q[k];
    end

    assign accept = bus.in_valid && load[0];

    // Accumulator lives at stage 0, so chained acc_en beats see the
    // previous result with no forwarding and no bubble.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            if (bus.acc_clr) begin
                acc_d = bus.a;
            end else if (bus.acc_en) begin
                acc_d = result;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            zr_q   <= '0;
            data_q <= '0;
            acc_q  <= ACC_INIT;
        end else begin
            vld_q  <= vld_d;
            zr_q   <= zr_d;
            data_q <= data_d;
            acc_q  <= acc_d;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out       = data_q[STAGES-1];
    assign bus.out_zr    = vld_q[STAGES-1] && zr_q[STAGES-1];
    assign bus.acc       = acc_q;

endmodule

// File: tb/tb_hlogic16_pipe.sv
module tb_hlogic16_pipe;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    logic        in_valid_v  = 1'b0;
    logic        out_ready_v = 1'b1;
    logic        acc_en_v    = 1'b0;
    logic        acc_clr_v   = 1'b0;
    logic [2:0]  op_v        = 3'd0;
    logic [63:0] a_v         = '0;
    logic [63:0] b_v         = '0;

    logic        obs_in_ready, obs_out_valid, obs_zr;
    logic [63:0] obs_out, obs_acc;

    hlogic16_pipe_if #(.WIDTH(16)) bus16 ();
    hlogic16_pipe_if #(.WIDTH(1))  bus1  ();
    hlogic16_pipe_if #(.WIDTH(32)) bus32 ();

    assign bus16.in_valid  = in_valid_v && (sel == 0);
    assign bus16.a         = a_v[15:0];
    assign bus16.b         = b_v[15:0];
    assign bus16.op        = op_v;
    assign bus16.acc_en    = acc_en_v;
    assign bus16.acc_clr   = acc_clr_v;
    assign bus16.out_ready = out_ready_v;

    assign bus1.in_valid   = in_valid_v && (sel == 1);
    assign bus1.a          = a_v[0:0];
    assign bus1.b          = b_v[0:0];
    assign bus1.op         = op_v;
    assign bus1.acc_en     = acc_en_v;
    assign bus1.acc_clr    = acc_clr_v;
    assign bus1.out_ready  = out_ready_v;

    assign bus32.in_valid  = in_valid_v && (sel == 2);
    assign bus32.a         = a_v[31:0];
    assign bus32.b         = b_v[31:0];
    assign bus32.op        = op_v;
    assign bus32.acc_en    = acc_en_v;
    assign bus32.acc_clr   = acc_clr_v;
    assign bus32.out_ready = out_ready_v;

    hlogic16_pipe #(.WIDTH(16), .STAGES(2)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    hlogic16_pipe #(.WIDTH(1),  .STAGES(1)) u_dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
    hlogic16_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

    always_comb begin
        obs_in_ready  = 1'b0;
        obs_out_valid = 1'b0;
        obs_out       = '0;
        obs_zr        = 1'b0;
        obs_acc       = '0;
        case (sel)
            0: begin
                obs_in_ready = bus16.in_ready; obs_out_valid = bus16.out_valid;
                obs_out = 64'(bus16.out); obs_zr = bus16.out_zr; obs_acc = 64'(bus16.acc);
            end
            1: begin
                obs_in_ready = bus1.in_ready; obs_out_valid = bus1.out_valid;
                obs_out = 64'(bus1.out); obs_zr = bus1.out_zr; obs_acc = 64'(bus1.acc);
            end
            default: begin
                obs_in_ready = bus32.in_ready; obs_out_valid = bus32.out_valid;
                obs_out = 64'(bus32.out); obs_zr = bus32.out_zr; obs_acc = 64'(bus32.acc);
            end
        endcase
    end

    typedef struct {
        logic [63:0] d;
        int          t;
    } ent_t;
    ent_t q[$];

    function automatic int w_of(input int s);
        return (s == 0) ? 16 : (s == 1) ? 1 : 32;
    endfunction

    function automatic int stg_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 1 : 4;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] x,
                                           input logic [63:0] y, input int w);
        logic [63:0] r;
        case (op)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        return r & mask_of(w);
    endfunction

    task automatic set_in(input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] op, input logic en, input logic clr);
        in_valid_v = v;
        a_v        = a;
        b_v        = b;
        op_v       = op;
        acc_en_v   = en;
        acc_clr_v  = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        out_ready_v = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs_out_valid !== 1'b0) begin
                failures++; $display("FAIL reset_out_valid sel=%0d got=%0b exp=0", s, obs_out_valid);
            end
            checks++;
            if (obs_out !== 64'd0) begin
                failures++; $display("FAIL reset_out sel=%0d got=%0h exp=0", s, obs_out);
            end
            checks++;
            if (obs_zr !== 1'b0) begin
                failures++; $display("FAIL reset_out_zr sel=%0d got=%0b exp=0", s, obs_zr);
            end
            checks++;
            if (obs_acc !== mask_of(w_of(s))) begin
                failures++; $display("FAIL reset_acc sel=%0d got=%0h exp=%0h", s, obs_acc, mask_of(w_of(s)));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        sel   = 0;
        #1;
        checks++;
        if (obs_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%0b exp=1", obs_in_ready);
        end
    endtask

    task automatic test_basic_ops();
        logic [15:0] exp_out [8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                    16'h0000, 16'h0000, 16'hFF00, 16'h00FF};
        int got = 0;
        sel = 0;
        out_ready_v = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) set_in(1'b1, 64'h00FF, 64'hFF00, 3'(c), 1'b0, 1'b0);
            else       set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
            #1;
            if (c < 8) begin
                checks++;
                if (obs_in_ready !== 1'b1) begin
                    failures++; $display("FAIL ops_in_ready c=%0d got=%0b exp=1", c, obs_in_ready);
                end
            end
            if (obs_out_valid === 1'b1 && got < 8) begin
                checks++;
                if (obs_out !== 64'(exp_out[got])) begin
                    failures++; $display("FAIL ops_out op=%0d got=%0h exp=%0h", got, obs_out, exp_out[got]);
                end
                checks++;
                if (obs_zr !== (exp_out[got] == 16'h0)) begin
                    failures++; $display("FAIL ops_zr op=%0d got=%0b exp=%0b", got, obs_zr, exp_out[got] == 16'h0);
                end
                checks++;
                if (c !== got + 2) begin
                    failures++; $display("FAIL ops_latency op=%0d got_cycle=%0d exp_cycle=%0d", got, c, got + 2);
                end
                got++;
            end
        end
        checks++;
        if (got !== 8) begin
            failures++; $display("FAIL ops_count got=%0d exp=8", got);
        end
    endtask

    task automatic test_legacy_and16();
        logic [15:0] va [4]  = '{16'h0001, 16'h00FF, 16'h0F0F, 16'hFFFF};
        logic [15:0] vb [4]  = '{16'h0001, 16'hFF00, 16'h00FF, 16'hFFFF};
        logic [15:0] vex [4] = '{16'h0001, 16'h0000, 16'h000F, 16'hFFFF};
        int got = 0;
        sel = 0;
        out_ready_v = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) set_in(1'b1, 64'(va[c]), 64'(vb[c]), 3'd0, 1'b0, 1'b0);
            else       set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
            #1;
            if (obs_out_valid === 1'b1 && got < 4) begin
                checks++;
                if (obs_out !== 64'(vex[got]) || obs_zr !== (vex[got] == 16'h0)) begin
                    failures++;
                    $display("FAIL and16_vec%0d got=%0h/zr%0b exp=%0h/zr%0b", got, obs_out, obs_zr,
                             vex[got], vex[got] == 16'h0);
                end
                got++;
            end
        end
        checks++;
        if (got !== 4) begin
            failures++; $display("FAIL and16_count got=%0d exp=4", got);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ba [4], bb [4], bex [4];
        logic [2:0]  bop [4];
        int nacc = 0, ngot = 0, first_c = -1;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            ba[i]  = 64'($urandom_range(0, 16'hFFFF));
            bb[i]  = 64'($urandom_range(0, 16'hFFFF));
            bop[i] = 3'($urandom_range(0, 7));
            bex[i] = ref_op(bop[i], ba[i], bb[i], 16);
        end
        out_ready_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_in(1'b1, ba[nacc], bb[nacc], bop[nacc], 1'b0, 1'b0);
            #1;
            if (obs_out_valid === 1'b1) begin
                checks++;
                if (obs_out !== bex[0]) begin
                    failures++; $display("FAIL stall_out_stable c=%0d got=%0h exp=%0h", c, obs_out, bex[0]);
                end
            end
            if (obs_in_ready === 1'b1) nacc++;
            if (nacc > 2) nacc = 2;
        end
        checks++;
        if (nacc !== 2) begin
            failures++; $display("FAIL stall_accepted got=%0d exp=2", nacc);
        end
        checks++;
        if (obs_in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_in_ready got=%0b exp=0", obs_in_ready);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready_v = 1'b1;
            if (nacc < 4) set_in(1'b1, ba[nacc], bb[nacc], bop[nacc], 1'b0, 1'b0);
            else          set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
            #1;
            if (obs_out_valid === 1'b1 && ngot < 4) begin
                if (first_c < 0) first_c = c;
                checks++;
                if (obs_out !== bex[ngot]) begin
                    failures++; $display("FAIL drain_order beat=%0d got=%0h exp=%0h", ngot, obs_out, bex[ngot]);
                end
                checks++;
                if (c !== first_c + ngot) begin
                    failures++; $display("FAIL drain_gap beat=%0d got_cycle=%0d exp_cycle=%0d", ngot, c, first_c + ngot);
                end
                ngot++;
            end
            if (in_valid_v && obs_in_ready === 1'b1) nacc++;
        end
        checks++;
        if (ngot !== 4 || nacc !== 4) begin
            failures++; $display("FAIL drain_count got=%0d/%0d exp=4/4", ngot, nacc);
        end
    endtask

    task automatic test_accumulator();
        logic [15:0] aex [3] = '{16'hFFFF, 16'h0FF0, 16'h0FFF};
        int got = 0;
        sel = 0;
        out_ready_v = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            case (c)
                0:       set_in(1'b1, 64'hFFFF, 64'h1234, 3'd7, 1'b0, 1'b1);
                1:       set_in(1'b1, 64'($urandom_range(0, 16'hFFFF)), 64'h0FF0, 3'd0, 1'b1, 1'b0);
                2:       set_in(1'b1, 64'($urandom_range(0, 16'hFFFF)), 64'h000F, 3'd1, 1'b1, 1'b0);
                default: set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
            endcase
            #1;
            if (obs_out_valid === 1'b1 && got < 3) begin
                checks++;
                if (obs_out !== 64'(aex[got]) || c !== got + 2) begin
                    failures++;
                    $display("FAIL acc_out beat=%0d got=%0h@%0d exp=%0h@%0d", got, obs_out, c, aex[got], got + 2);
                end
                got++;
            end
        end
        checks++;
        if (got !== 3) begin
            failures++; $display("FAIL acc_count got=%0d exp=3", got);
        end
        checks++;
        if (obs_acc !== 64'h0FFF) begin
            failures++; $display("FAIL acc_final got=%0h exp=0fff", obs_acc);
        end
    endtask

    task automatic test_async_reset();
        int got = 0;
        sel = 0;
        out_ready_v = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c < 2) set_in(1'b1, 64'h00AA, 64'h00FF, 3'd1, 1'b0, 1'b0);
            else       set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
        end
        #1;
        checks++;
        if (obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0 || obs_acc !== 64'h0FFF) begin
            failures++;
            $display("FAIL arst_pre got=v%0b/r%0b/acc%0h exp=v1/r0/acc0fff", obs_out_valid, obs_in_ready, obs_acc);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_out_valid !== 1'b0 || obs_out !== 64'd0 || obs_zr !== 1'b0) begin
            failures++;
            $display("FAIL arst_outputs got=v%0b/%0h/zr%0b exp=v0/0/zr0", obs_out_valid, obs_out, obs_zr);
        end
        checks++;
        if (obs_acc !== 64'hFFFF) begin
            failures++; $display("FAIL arst_acc got=%0h exp=ffff", obs_acc);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready_v = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) set_in(1'b1, 64'h1234, 64'h00FF, 3'd0, 1'b0, 1'b0);
            else        set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
            #1;
            if (obs_out_valid === 1'b1) begin
                checks++;
                if (obs_out !== 64'h0034 || c !== 2) begin
                    failures++; $display("FAIL arst_fresh got=%0h@%0d exp=0034@2", obs_out, c);
                end
                got++;
            end
        end
        checks++;
        if (got !== 1) begin
            failures++; $display("FAIL arst_fresh_count got=%0d exp=1", got);
        end
    endtask

    task automatic test_sweep(input int s, input int n);
        int          w, stg;
        logic [63:0] m, macc, aeff, res;
        logic        exp_ir, exp_ov;
        sel  = s;
        w    = w_of(s);
        stg  = stg_of(s);
        m    = mask_of(w);
        do_reset();
        q.delete();
        macc = m;
        for (int c = 0; c < n + 40; c++) begin
            @(negedge clk);
            if (c < n) begin
                set_in($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                       3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
                out_ready_v = ($urandom_range(0, 3) != 0);
            end else begin
                set_in(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
                out_ready_v = 1'b1;
            end
            #1;
            exp_ir = (q.size() < stg) || out_ready_v;
            exp_ov = (q.size() > 0) && (c >= q[0].t + stg);
            checks++;
            if (obs_in_ready !== exp_ir) begin
                failures++; $display("FAIL sweep%0d_in_ready c=%0d got=%0b exp=%0b", s, c, obs_in_ready, exp_ir);
            end
            checks++;
            if (obs_out_valid !== exp_ov) begin
                failures++; $display("FAIL sweep%0d_out_valid c=%0d got=%0b exp=%0b", s, c, obs_out_valid, exp_ov);
            end
            if (exp_ov) begin
                checks++;
                if (obs_out !== q[0].d || obs_zr !== (q[0].d == 64'd0)) begin
                    failures++;
                    $display("FAIL sweep%0d_out c=%0d got=%0h/zr%0b exp=%0h/zr%0b", s, c, obs_out, obs_zr,
                             q[0].d, q[0].d == 64'd0);
                end
            end else begin
                checks++;
                if (obs_zr !== 1'b0) begin
                    failures++; $display("FAIL sweep%0d_zr_idle c=%0d got=%0b exp=0", s, c, obs_zr);
                end
            end
            checks++;
            if (obs_acc !== macc) begin
                failures++; $display("FAIL sweep%0d_acc c=%0d got=%0h exp=%0h", s, c, obs_acc, macc);
            end
            if (exp_ov && out_ready_v) void'(q.pop_front());
            if (in_valid_v && exp_ir) begin
                aeff = (acc_en_v && !acc_clr_v) ? macc : (a_v & m);
                res  = ref_op(op_v, aeff, b_v & m, w);
                q.push_back('{d: res, t: c});
                if (acc_clr_v)     macc = a_v & m;
                else if (acc_en_v) macc = res;
            end
        end
        checks++;
        if (q.size() !== 0) begin
            failures++; $display("FAIL sweep%0d_leftover got=%0d exp=0", s, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_legacy_and16();
        test_backpressure();
        test_accumulator();
        test_async_reset();
        test_sweep(0, 300);
        test_sweep(1, 300);
        test_sweep(2, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
